// File: rtl/ov7670_config_sequencer_pkg.sv
// Shared OV7670 camera definitions: ROM sentinels, sequencer state encoding
// and the clock-derived default settle time.
package ov7670_config_sequencer_pkg;

    localparam int CLK_FREQ = 24_000_000;
    // One settle entry waits 10 ms.
    localparam int DEFAULT_DELAY_CYCLES = CLK_FREQ / 100;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register-init ROM and hands each {reg, value} entry to the
// SCCB write master, honouring the settle-delay and end-of-table sentinels.
module ov7670_config_sequencer
    import ov7670_config_sequencer_pkg::*;
#(
    parameter int DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              sccb_valid,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_data,
    input  logic              sccb_ready,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    seq_state_t       state;
    logic [CNT_W-1:0] delay_cnt;
    logic             at_last_addr;

    assign at_last_addr = (rom_addr == ADDR_MAX);

    // Handshake: once sccb_valid rises, sccb_reg/sccb_data stay frozen until a
    // cycle with sccb_valid & sccb_ready; that cycle is the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            delay_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_addr <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (rom_dout == ROM_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (rom_dout == ROM_DELAY) begin
                        delay_cnt <= '0;
                        state     <= ST_DELAY;
                    end else begin
                        sccb_reg   <= rom_dout[15:8];
                        sccb_data  <= rom_dout[7:0];
                        sccb_valid <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sccb_ready) begin
                        sccb_valid <= 1'b0;
                        // The top ROM entry is the last one; never wrap to 0.
                        if (at_last_addr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_DELAY: begin
                    delay_cnt <= delay_cnt + 1'b1;
                    if (delay_cnt == CNT_LAST) begin
                        if (at_last_addr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: table of ROM scenarios checked against a
// ROM-walk model, plus hand-written stall, gap, restart and reset sequences.
module tb_ov7670_config_sequencer;

    localparam int DELAY  = 8;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_dout;
    logic              sccb_valid;
    logic [7:0]        sccb_reg;
    logic [7:0]        sccb_data;
    logic              sccb_ready;
    logic              busy;
    logic              done;

    ov7670_config_sequencer #(.DELAY_CYCLES(DELAY), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_valid (sccb_valid),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .sccb_ready (sccb_ready),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous ROM model ----------------
    logic [15:0] rom [0:255];
    logic [15:0] ov_tab [0:75];
    initial rom_dout = 16'h0000;
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // ---------------- transfer monitor ----------------
    logic [15:0] got_q[$];
    int          hs_q[$];
    int          rise_q[$];
    int          cyc;
    logic        prev_valid;
    initial begin
        cyc        = 0;
        prev_valid = 1'b0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sccb_valid && sccb_ready) begin
            got_q.push_back({sccb_reg, sccb_data});
            hs_q.push_back(cyc);
        end
        if (sccb_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid <= sccb_valid;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
        end
    endtask

    task automatic load_rom(input int kind);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        case (kind)
            0: begin
                rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
            end
            1: for (int i = 0; i < 76; i++) rom[i] = ov_tab[i];
            2: for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
            3: rom[0] = 16'hFFFF;
            4: begin
                rom[0] = 16'hFF12; rom[1] = 16'hFFF0; rom[2] = 16'hFF00; rom[3] = 16'hFFFF;
            end
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic clear_mon();
        got_q.delete();
        hs_q.delete();
        rise_q.delete();
    endtask

    typedef struct {
        int rom_kind;
        int stall;
        int start_mid;
        int exp_writes;
        int exp_addr;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        ov_tab = '{
            16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h0400, 16'h8C02,
            16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7,
            16'h54E4, 16'h589E, 16'h3DC0, 16'h1714, 16'h1839, 16'h3203, 16'h1903, 16'h1A7B,
            16'h030A, 16'h0F41, 16'h1E00, 16'h330B, 16'h3C78, 16'h6900, 16'h7400, 16'hB084,
            16'hB10C, 16'hB20E, 16'hB380, 16'h7A20, 16'h7B10, 16'h7C1E, 16'h7D35, 16'h7E5A,
            16'h7F69, 16'h8076, 16'h8180, 16'h8288, 16'h838F, 16'h8496, 16'h85A3, 16'h86AF,
            16'h87C4, 16'h88D7, 16'h89E8, 16'h13E0, 16'h0000, 16'h1000, 16'h0D40, 16'h1418,
            16'hA505, 16'hAB07, 16'h2495, 16'h2533, 16'h26E3, 16'h9F78, 16'hA068, 16'hA103,
            16'hA6D8, 16'hA7D8, 16'hA8F0, 16'hA990, 16'hAA94, 16'h13E5, 16'h0E61, 16'h0F4B,
            16'h1602, 16'h1E07, 16'h13A7, 16'hFFFF
        };
        //            kind stall mid writes addr
        vecs[0] = '{0,   0,    0,  2,     3};
        vecs[1] = '{0,   5,    0,  2,     3};
        vecs[2] = '{1,   0,    0,  74,    75};
        vecs[3] = '{2,   0,    0,  256,   255};
        vecs[4] = '{3,   0,    0,  0,     0};
        vecs[5] = '{4,   0,    0,  2,     3};
        vecs[6] = '{0,   0,    6,  2,     3};

        n_checks   = 0;
        n_fail     = 0;
        start      = 1'b0;
        sccb_ready = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr",  {24'd0, rom_addr},   32'd0);
        chk("rst_valid", {31'd0, sccb_valid}, 32'd0);
        chk("rst_reg",   {24'd0, sccb_reg},   32'd0);
        chk("rst_data",  {24'd0, sccb_data},  32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_done",  {31'd0, done},       32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven scenarios
        for (int v = 0; v < 7; v++) begin
            string nm;
            int    n;
            nm = $sformatf("vec%0d", v);
            load_rom(vecs[v].rom_kind);
            build_exp();
            clear_mon();
            sccb_ready = (vecs[v].stall == 0);
            pulse_start();
            chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            if (vecs[v].stall > 0) begin
                n = 0;
                while (!sccb_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < vecs[v].stall; k++) begin
                    chk($sformatf("%s_stall%0d_valid", nm, k), {31'd0, sccb_valid}, 32'd1);
                    chk($sformatf("%s_stall%0d_regdata", nm, k), {16'd0, sccb_reg, sccb_data}, {16'd0, exp_q[0]});
                    chk($sformatf("%s_stall%0d_addr", nm, k), {24'd0, rom_addr}, 32'd0);
                    @(negedge clk);
                end
                sccb_ready = 1'b1;
            end
            if (vecs[v].start_mid > 0) begin
                repeat (vecs[v].start_mid) @(negedge clk);
                pulse_start();
            end
            wait_done(nm);
            repeat (4) @(negedge clk);
            chk({nm, "_writes"}, got_q.size(), vecs[v].exp_writes);
            chk({nm, "_addr"}, {24'd0, rom_addr}, vecs[v].exp_addr);
            chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
            chk({nm, "_done_end"}, {31'd0, done}, 32'd1);
            chk({nm, "_valid_end"}, {31'd0, sccb_valid}, 32'd0);
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                chk($sformatf("%s_write%0d", nm, i), {16'd0, got_q[i]}, {16'd0, exp_q[i]});
            if (v == 2 && got_q.size() == 74) begin
                chk("ov_entry7", {16'd0, got_q[6]}, 32'h8C02);
                chk("ov_last",   {16'd0, got_q[73]}, 32'h13A7);
            end
        end

        // Gap from first handshake to second valid rise: FETCH, DECODE,
        // DELAY x DELAY, FETCH, DECODE, then the rise seen one edge later.
        load_rom(0);
        clear_mon();
        sccb_ready = 1'b1;
        pulse_start();
        wait_done("gap");
        chk("gap_hs_count",   hs_q.size(),   32'd2);
        chk("gap_rise_count", rise_q.size(), 32'd2);
        if (hs_q.size() >= 1 && rise_q.size() >= 2)
            chk("gap_cycles", rise_q[1] - hs_q[0], 5 + DELAY);

        // Restart from DONE: done clears next cycle, rerun from address 0
        clear_mon();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_done", {31'd0, done},     32'd0);
        chk("restart_busy", {31'd0, busy},     32'd1);
        chk("restart_addr", {24'd0, rom_addr}, 32'd0);
        wait_done("restart");
        repeat (2) @(negedge clk);
        chk("restart_writes", got_q.size(), 32'd2);

        // Async reset during DELAY
        clear_mon();
        pulse_start();
        repeat (7) @(negedge clk);
        chk("rdly_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rdly_addr",  {24'd0, rom_addr},   32'd0);
        chk("rdly_valid", {31'd0, sccb_valid}, 32'd0);
        chk("rdly_reg",   {24'd0, sccb_reg},   32'd0);
        chk("rdly_busy",  {31'd0, busy},       32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rdly_idle_busy", {31'd0, busy},       32'd0);
        chk("rdly_idle_done", {31'd0, done},       32'd0);
        chk("rdly_idle_addr", {24'd0, rom_addr},   32'd0);
        chk("rdly_idle_valid", {31'd0, sccb_valid}, 32'd0);

        // Async reset during SEND
        sccb_ready = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("rsend_pre_valid", {31'd0, sccb_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rsend_valid", {31'd0, sccb_valid}, 32'd0);
        chk("rsend_data",  {24'd0, sccb_data},  32'd0);
        chk("rsend_busy",  {31'd0, busy},       32'd0);
        sccb_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rsend_idle_busy",  {31'd0, busy},       32'd0);
        chk("rsend_idle_valid", {31'd0, sccb_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
